// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM-like port between IF and MEM, one transaction in flight
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_addr_ok,
  output logic                if_data_ok,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_wr,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_addr_ok,
  output logic                mem_data_ok,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                ram_req,
  output logic                ram_wr,
  output logic [DATA_W/8-1:0] ram_wstrb,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic                ram_addr_ok,
  input  logic                ram_data_ok,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state, state_nxt;
  logic             owner_mem;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_mem, grant_if, done;

  always_comb begin
    state_nxt   = state;
    grant_mem   = 1'b0;
    grant_if    = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        // MEM wins unless IF has already been passed over STARVE_LIMIT times in a row
        grant_mem = mem_req && !(if_req && (starve_cnt == CNT_MAX));
        grant_if  = if_req && !grant_mem;
        if (grant_mem || grant_if) state_nxt = REQ;
      end
      REQ: begin
        if (ram_addr_ok) begin
          if (ram_data_ok) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (ram_data_ok) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // state is IDLE throughout reset, so only the grant strobes need masking
    if_addr_ok  = grant_if && !reset;
    mem_addr_ok = grant_mem && !reset;
    if_data_ok  = done && !owner_mem;
    mem_data_ok = done && owner_mem;
    if_rdata    = ram_rdata;
    mem_rdata   = ram_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_mem  <= 1'b0;
      starve_cnt <= '0;
      ram_req    <= 1'b0;
      ram_wr     <= 1'b0;
      ram_wstrb  <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_mem || grant_if) begin
        owner_mem <= grant_mem;
        ram_req   <= 1'b1;
        ram_wr    <= grant_mem && mem_wr;
        ram_wstrb <= grant_mem ? mem_wstrb : '0;
        ram_addr  <= grant_mem ? mem_addr : if_addr;
        ram_wdata <= grant_mem ? mem_wdata : '0;
        if (grant_mem && if_req)
          starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
        else
          starve_cnt <= '0;
      end else if (state == REQ && ram_addr_ok) begin
        ram_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_wr = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        ram_addr_ok = 1'b0, ram_data_ok = 1'b0;
  logic        if_addr_ok, if_data_ok, mem_addr_ok, mem_data_ok;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        ram_req, ram_wr;
  logic [3:0]  ram_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_addr_ok(if_addr_ok),
    .if_data_ok(if_data_ok), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_wr(ram_wr), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok),
    .ram_rdata(ram_rdata)
  );

  int n_assert = 0, n_fail = 0, cyc = 0;
  // transaction-level reference: 0 nothing in flight, 1 awaiting memory accept, 2 awaiting response
  int phase = 0, streak = 0;
  logic        x_mem = 1'b0, x_wr = 1'b0;
  logic [3:0]  x_wstrb = '0;
  logic [31:0] x_addr = '0, x_wdata = '0;
  int p_acc = 100, p_data = 100, p_tog = 0, p_spur = 0;
  int if_mode = 0, mem_mode = 0;  // 0 one-shot, 1 always held, 2 random
  logic if_wait = 1'b0, mem_wait = 1'b0;
  logic g_if = 1'b0, g_mem = 1'b0, d_if = 1'b0, d_mem = 1'b0;
  logic use_fixed = 1'b0;
  logic [31:0] fixed_rdata = '0, last_rdata = '0;
  int glog[$];
  int last_grant_cyc = 0, last_done_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic check_cycle();
    logic eg_mem, eg_if, edone;
    cyc++;
    g_if = 1'b0; g_mem = 1'b0; d_if = 1'b0; d_mem = 1'b0;
    if (reset) begin
      chk("rst_if_addr_ok", 64'(if_addr_ok), 64'(0));
      chk("rst_mem_addr_ok", 64'(mem_addr_ok), 64'(0));
      chk("rst_if_data_ok", 64'(if_data_ok), 64'(0));
      chk("rst_mem_data_ok", 64'(mem_data_ok), 64'(0));
      chk("rst_ram_req", 64'(ram_req), 64'(0));
      chk("rst_ram_fields", {27'd0, ram_wr, ram_wstrb, ram_addr}, 64'(0));
      chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
      phase = 0;
      streak = 0;
      return;
    end
    eg_mem = (phase == 0) && mem_req && !(if_req && streak == LIM);
    eg_if  = (phase == 0) && if_req && !eg_mem;
    chk("if_addr_ok", 64'(if_addr_ok), 64'(eg_if));
    chk("mem_addr_ok", 64'(mem_addr_ok), 64'(eg_mem));
    chk("ram_req", 64'(ram_req), 64'(phase == 1));
    if (phase == 1) begin
      chk("ram_addr", 64'(ram_addr), 64'(x_addr));
      chk("ram_wr", 64'(ram_wr), 64'(x_wr));
      chk("ram_wstrb", 64'(ram_wstrb), 64'(x_wstrb));
      if (x_mem) chk("ram_wdata", 64'(ram_wdata), 64'(x_wdata));
    end
    edone = ram_data_ok && (phase == 2 || (phase == 1 && ram_addr_ok));
    d_if  = edone && !x_mem;
    d_mem = edone && x_mem;
    chk("if_data_ok", 64'(if_data_ok), 64'(d_if));
    chk("mem_data_ok", 64'(mem_data_ok), 64'(d_mem));
    if (d_if) chk("if_rdata", 64'(if_rdata), 64'(ram_rdata));
    if (d_mem && !x_wr) chk("mem_rdata", 64'(mem_rdata), 64'(ram_rdata));
    if (if_addr_ok || mem_addr_ok) begin
      glog.push_back(int'(mem_addr_ok));
      last_grant_cyc = cyc;
    end
    if (if_data_ok || mem_data_ok) begin
      last_done_cyc = cyc;
      last_rdata = if_data_ok ? if_rdata : mem_rdata;
    end
    if (edone) phase = 0;
    else if (phase == 1 && ram_addr_ok) phase = 2;
    if (eg_mem || eg_if) begin
      phase   = 1;
      x_mem   = eg_mem;
      x_wr    = eg_mem && mem_wr;
      x_wstrb = eg_mem ? mem_wstrb : 4'd0;
      x_addr  = eg_mem ? mem_addr : if_addr;
      x_wdata = mem_wdata;
      streak  = (eg_mem && if_req) ? ((streak < LIM) ? streak + 1 : LIM) : 0;
    end
    g_if = eg_if;
    g_mem = eg_mem;
  endtask

  task automatic drive();
    ram_addr_ok = (phase == 1) && pct(p_acc);
    if (phase == 2) ram_data_ok = pct(p_data);
    else if (phase == 1 && ram_addr_ok) ram_data_ok = pct(p_tog);
    else ram_data_ok = pct(p_spur);
    ram_rdata = use_fixed ? fixed_rdata : $urandom;
    if (g_if) begin
      if (if_mode != 1) if_req = 1'b0;
      if_wait = 1'b1;
      if_addr = $urandom;
    end
    if (d_if) if_wait = 1'b0;
    if (if_mode == 2 && !if_req && !if_wait && pct(60)) begin
      if_req = 1'b1;
      if_addr = $urandom;
    end
    if (g_mem) begin
      if (mem_mode != 1) mem_req = 1'b0;
      mem_wait = 1'b1;
      mem_wr = 1'($urandom); mem_wstrb = 4'($urandom);
      mem_addr = $urandom; mem_wdata = $urandom;
    end
    if (d_mem) mem_wait = 1'b0;
    if (mem_mode == 2 && !mem_req && !mem_wait && pct(70)) begin
      mem_req = 1'b1;
      mem_wr = 1'($urandom); mem_wstrb = 4'($urandom);
      mem_addr = $urandom; mem_wdata = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic settle(input int max);
    int n = 0;
    while (!(phase == 0 && !if_req && !mem_req) && n < max) begin
      tick();
      n++;
    end
    chk("settle_bound", 64'(n < max), 64'(1));
  endtask

  initial begin
    int n;
    int rcyc;
    int pat3[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    int pat6[5]  = '{1, 1, 1, 1, 0};

    // reset holds every output low even with both requesters asking
    if_req = 1'b1; mem_req = 1'b1;
    tick(); tick();
    if_req = 1'b0; mem_req = 1'b0;
    reset = 1'b0;
    tick();

    // 1: lone IF fetch at minimum latency
    use_fixed = 1'b1; fixed_rdata = 32'h02800C0C;
    if_addr = 32'h1C000000; if_req = 1'b1;
    settle(20);
    chk("t1_latency", 64'(last_done_cyc - last_grant_cyc), 64'(2));
    chk("t1_rdata", 64'(last_rdata), 64'h02800C0C);
    chk("t1_owner", 64'(glog[glog.size()-1]), 64'(0));
    use_fixed = 1'b0;

    // 2: simultaneous requests, MEM load goes first
    glog.delete();
    if_addr = 32'h1C000004; if_req = 1'b1;
    mem_wr = 1'b0; mem_addr = 32'h1C001000; mem_req = 1'b1;
    settle(30);
    chk("t2_grants", 64'(glog.size()), 64'(2));
    chk("t2_first_mem", 64'(glog[0]), 64'(1));
    chk("t2_second_if", 64'(glog[1]), 64'(0));

    // 3: both held -> starvation limit forces IF every fifth grant
    glog.delete();
    if_mode = 1; mem_mode = 1; if_req = 1'b1; mem_req = 1'b1;
    n = 0;
    while (glog.size() < 11 && n < 200) begin tick(); n++; end
    chk("t3_bound", 64'(n < 200), 64'(1));
    foreach (pat3[i]) chk($sformatf("t3_grant%0d", i), 64'(glog[i]), 64'(pat3[i]));
    if_mode = 0; mem_mode = 0; if_req = 1'b0; mem_req = 1'b0;
    settle(20);

    // 4: store with a slow memory accept
    glog.delete();
    p_acc = 30;
    mem_wr = 1'b1; mem_wstrb = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
    mem_req = 1'b1;
    settle(100);
    chk("t4_mem_grant", 64'(glog[0]), 64'(1));
    chk("t4_ack_after_grant", 64'(last_done_cyc > last_grant_cyc), 64'(1));
    p_acc = 100;

    // 5: accept and response together in the first REQ cycle
    p_tog = 100;
    mem_wr = 1'b0; mem_addr = 32'h200; mem_req = 1'b1;
    settle(20);
    chk("t5_latency", 64'(last_done_cyc - last_grant_cyc), 64'(1));
    p_tog = 0;
    tick(); tick();

    // 6: reset while waiting for a response, then a stale response
    glog.delete();
    if_mode = 1; mem_mode = 1; if_req = 1'b1; mem_req = 1'b1;
    n = 0;
    while (glog.size() < 2 && n < 50) begin tick(); n++; end
    p_data = 0;
    tick();
    chk("t6_in_resp", 64'(phase), 64'(2));
    rcyc = cyc;
    reset = 1'b1;
    if_mode = 0; mem_mode = 0; if_req = 1'b0; mem_req = 1'b0; p_spur = 100;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("t6_no_data_ok", 64'(last_done_cyc < rcyc), 64'(1));
    p_spur = 0; p_data = 100;
    glog.delete();
    if_mode = 1; mem_mode = 1; if_req = 1'b1; mem_req = 1'b1;
    n = 0;
    while (glog.size() < 5 && n < 100) begin tick(); n++; end
    chk("t6_bound", 64'(n < 100), 64'(1));
    foreach (pat6[i]) chk($sformatf("t6_grant%0d", i), 64'(glog[i]), 64'(pat6[i]));
    if_mode = 0; mem_mode = 0; if_req = 1'b0; mem_req = 1'b0;
    settle(20);

    // random traffic with random memory timing and stray responses
    if_wait = 1'b0; mem_wait = 1'b0;
    if_mode = 2; mem_mode = 2;
    p_acc = 50; p_data = 40; p_tog = 25; p_spur = 15;
    repeat (3000) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
